// File: rtl/wca_dduc_strobe_ctrl.sv
// wca_dduc_strobe_ctrl
// DDC/DUC rate and strobe controller for the wca front end.
//  - Divides the IF sample strobe down to the CIC rate strobe and the
//    baseband strobe (optional real-halfband divide-by-2).
//  - NCO phase accumulator with programmable frequency and phase offset.
//  - Rate changes are staged in a shadow register and applied only at a
//    strobe-period boundary (or while disabled), so the CIC never sees a
//    truncated period.
// Optional build macro: WCA_DDUC_PHASE_DITHER_EN adds LFSR dither LSBs to
// the phase output.
//
// Strobe semantics: every strobe input/output is a single-cycle,
// active-high pulse qualified by nothing else; there is no back-pressure.
// strobe_if is consumed on a clock edge only when enable is high.
// strobe_cic/strobe_bb/rate_update are valid for exactly one cycle and a
// downstream consumer must sample them on that cycle.

module wca_dduc_strobe_ctrl #(
   parameter int RATE_W       = 13,
   parameter int PHASE_W      = 32,
   parameter int RATE_DEFAULT = 1,
   parameter int DITHER_BITS  = 4
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               enable,
   input  logic               strobe_if,
   input  logic               reg_we,
   input  logic [1:0]         reg_addr,
   input  logic [31:0]        reg_data,
   output logic [7:0]         cfg,
   output logic [RATE_W-1:0]  rate,
   output logic               rate_update,
   output logic [4:0]         log2_rate,
   output logic               strobe_cic,
   output logic               strobe_bb,
   output logic [PHASE_W-1:0] phase
);

   // Register map
   localparam logic [1:0] ADDR_FREQ   = 2'd0;
   localparam logic [1:0] ADDR_RATE   = 2'd1;
   localparam logic [1:0] ADDR_CONFIG = 2'd2;
   localparam logic [1:0] ADDR_OFFSET = 2'd3;

   // Config bit positions
   localparam int CFG_CORDIC_BYPASS = 2;
   localparam int CFG_CIC_BYPASS    = 4;
   localparam int CFG_HB_BYPASS     = 5;
   localparam int CFG_PHASE_CLEAR   = 6;

   localparam logic [RATE_W-1:0] RATE_RST = RATE_W'(RATE_DEFAULT);
   localparam logic [RATE_W-1:0] RATE_ONE = RATE_W'(1);

   // ------------------------------------------------------------------
   // Internal state
   // ------------------------------------------------------------------
   logic [PHASE_W-1:0] freq;
   logic [PHASE_W-1:0] offset;
   logic [PHASE_W-1:0] acc;
   logic [RATE_W-1:0]  pending;
   logic               pending_flag;
   logic [RATE_W-1:0]  cnt;
   logic               bb_toggle;

   // ------------------------------------------------------------------
   // Decode and shared combinational terms
   // ------------------------------------------------------------------
   logic               wr_freq;
   logic               wr_rate;
   logic               wr_cfg;
   logic               wr_offset;
   logic               phase_clear;
   logic               fire;
   logic [RATE_W-1:0]  rate_eff;
   logic               cnt_wrap;
   logic               rate_apply;
   logic [PHASE_W-1:0] acc_next;
   logic [PHASE_W-1:0] phase_sum;

   assign wr_freq     = reg_we && (reg_addr == ADDR_FREQ);
   assign wr_rate     = reg_we && (reg_addr == ADDR_RATE);
   assign wr_cfg      = reg_we && (reg_addr == ADDR_CONFIG);
   assign wr_offset   = reg_we && (reg_addr == ADDR_OFFSET);
   assign phase_clear = wr_cfg && reg_data[CFG_PHASE_CLEAR];

   // An IF sample is only consumed while the block is enabled
   assign fire = enable && strobe_if;

   // A programmed rate of 0 behaves as divide-by-1
   assign rate_eff = (rate == '0) ? RATE_ONE : rate;
   assign cnt_wrap = (cnt == (rate_eff - RATE_ONE));

   // Shadow rate is applied on the last sample of a period, or at once
   // while disabled since there is no period in flight then
   assign rate_apply = pending_flag && ((fire && cnt_wrap) || !enable);

   assign acc_next = acc + freq;

`ifdef WCA_DDUC_PHASE_DITHER_EN
   // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting towards bit 0
   logic [15:0]        lfsr;
   logic               lfsr_fb;
   logic [PHASE_W-1:0] dither;

   assign lfsr_fb = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];
   assign dither  = PHASE_W'(lfsr[DITHER_BITS-1:0]);
   assign phase_sum = acc_next + offset + dither;

   // Dither sequence advances once per consumed IF sample
   always_ff @(posedge clock) begin
      if (reset) begin
         lfsr <= 16'hACE1;
      end else if (fire) begin
         lfsr <= {lfsr_fb, lfsr[15:1]};
      end
   end
`else
   assign phase_sum = acc_next + offset;
`endif

   // ------------------------------------------------------------------
   // Register file: config, frequency word, phase offset
   // ------------------------------------------------------------------

   // Bus writes land on the next edge; phase_clear never sticks in cfg
   always_ff @(posedge clock) begin
      if (reset) begin
         cfg    <= '0;
         freq   <= '0;
         offset <= '0;
      end else begin
         if (wr_cfg) begin
            cfg                  <= reg_data[7:0];
            cfg[CFG_PHASE_CLEAR] <= 1'b0;
         end
         if (wr_freq) begin
            freq <= reg_data[PHASE_W-1:0];
         end
         if (wr_offset) begin
            offset <= reg_data[PHASE_W-1:0];
         end
      end
   end

   // ------------------------------------------------------------------
   // Shadow rate register
   // ------------------------------------------------------------------

   // A write on the apply edge re-arms the shadow; the old value is applied
   always_ff @(posedge clock) begin
      if (reset) begin
         pending      <= '0;
         pending_flag <= 1'b0;
      end else begin
         if (rate_apply) begin
            pending_flag <= 1'b0;
         end
         if (wr_rate) begin
            pending      <= reg_data[RATE_W-1:0];
            pending_flag <= 1'b1;
         end
      end
   end

   // ------------------------------------------------------------------
   // Rate counter, CIC strobe, halfband toggle, rate apply
   // ------------------------------------------------------------------

   // Divide consumed IF samples by the active rate; apply overrides all
   always_ff @(posedge clock) begin
      if (reset) begin
         rate        <= RATE_RST;
         cnt         <= '0;
         bb_toggle   <= 1'b0;
         strobe_cic  <= 1'b0;
         rate_update <= 1'b0;
      end else begin
         rate_update <= rate_apply;
         strobe_cic  <= fire && (cfg[CFG_CIC_BYPASS] || (cnt == '0));

         if (!enable) begin
            cnt       <= '0;
            bb_toggle <= 1'b0;
         end else begin
            if (fire) begin
               cnt <= cnt_wrap ? '0 : (cnt + RATE_ONE);
            end
            if (strobe_cic) begin
               bb_toggle <= ~bb_toggle;
            end
         end

         if (rate_apply) begin
            rate      <= pending;
            cnt       <= '0;
            bb_toggle <= 1'b0;
         end
      end
   end

   // Baseband strobe: every CIC strobe in bypass, else every second one
   assign strobe_bb = strobe_cic && (cfg[CFG_HB_BYPASS] || bb_toggle);

   // ------------------------------------------------------------------
   // NCO phase accumulator and phase output
   // ------------------------------------------------------------------

   // Accumulate per consumed sample; phase_clear wins over accumulation
   always_ff @(posedge clock) begin
      if (reset) begin
         acc   <= '0;
         phase <= '0;
      end else begin
         if (fire) begin
            acc   <= acc_next;
            phase <= cfg[CFG_CORDIC_BYPASS] ? '0 : phase_sum;
         end
         if (phase_clear) begin
            acc <= '0;
         end
      end
   end

   // ------------------------------------------------------------------
   // floor(log2(rate)), 0 for rate 0 or 1
   // ------------------------------------------------------------------

   // Priority encoder: the highest set bit above bit 0 wins
   always_comb begin
      log2_rate = '0;
      for (int b = 1; b < RATE_W; b++) begin
         if (rate[b]) begin
            log2_rate = 5'(b);
         end
      end
   end

endmodule

// File: tb/tb_wca_dduc_strobe_ctrl.sv
// tb_wca_dduc_strobe_ctrl
// Self-checking bench for wca_dduc_strobe_ctrl. A behavioural model steps
// on every rising edge and queues the expected output vector; a monitor
// on the falling edge pops and compares it against the DUT. Directed
// sequences add explicit checks on pulse counts and phase values.

module tb_wca_dduc_strobe_ctrl;

   localparam int RATE_W       = 13;
   localparam int PHASE_W      = 32;
   localparam int RATE_DEFAULT = 1;
   localparam int DITHER_BITS  = 4;
   localparam int OUT_W        = 8 + RATE_W + 1 + 5 + 1 + 1 + PHASE_W;
   localparam longint PH_MOD   = longint'(1) << PHASE_W;

   // ------------------------------------------------------------------
   // DUT signals and instance
   // ------------------------------------------------------------------
   logic               clock;
   logic               reset;
   logic               enable;
   logic               strobe_if;
   logic               reg_we;
   logic [1:0]         reg_addr;
   logic [31:0]        reg_data;
   logic [7:0]         cfg;
   logic [RATE_W-1:0]  rate;
   logic               rate_update;
   logic [4:0]         log2_rate;
   logic               strobe_cic;
   logic               strobe_bb;
   logic [PHASE_W-1:0] phase;

   wca_dduc_strobe_ctrl #(
      .RATE_W       (RATE_W),
      .PHASE_W      (PHASE_W),
      .RATE_DEFAULT (RATE_DEFAULT),
      .DITHER_BITS  (DITHER_BITS)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .strobe_if   (strobe_if),
      .reg_we      (reg_we),
      .reg_addr    (reg_addr),
      .reg_data    (reg_data),
      .cfg         (cfg),
      .rate        (rate),
      .rate_update (rate_update),
      .log2_rate   (log2_rate),
      .strobe_cic  (strobe_cic),
      .strobe_bb   (strobe_bb),
      .phase       (phase)
   );

   // ------------------------------------------------------------------
   // Clock
   // ------------------------------------------------------------------
   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ------------------------------------------------------------------
   // Counters and scoreboard queue
   // ------------------------------------------------------------------
   int n_cmp = 0;
   int n_err = 0;
   logic [OUT_W-1:0] exp_q[$];

   // ------------------------------------------------------------------
   // Behavioural reference model (spec rules, plain arithmetic)
   // ------------------------------------------------------------------
   logic [7:0] m_cfg;
   int         m_rate;
   int         m_pend;
   bit         m_pflag;
   int         m_cnt;      // sample index within the current period
   bit         m_tog;      // which half of a baseband pair we are in
   bit         m_cic;
   bit         m_upd;
   longint     m_freq;
   longint     m_off;
   longint     m_acc;
   longint     m_phase;
   logic [15:0] m_lfsr;

   function automatic int floor_log2(int r);
      int l = 0;
      while ((2 << l) <= r) l++;
      return l;
   endfunction

   function automatic logic [OUT_W-1:0] model_vec();
      bit bb;
      bb = m_cic && (m_cfg[5] || m_tog);
      return {m_cfg, RATE_W'(m_rate), m_upd, 5'(floor_log2(m_rate)),
              m_cic, bb, PHASE_W'(m_phase)};
   endfunction

   task automatic model_reset();
      m_cfg = 8'h00; m_rate = RATE_DEFAULT; m_pend = 0; m_pflag = 0;
      m_cnt = 0; m_tog = 0; m_cic = 0; m_upd = 0;
      m_freq = 0; m_off = 0; m_acc = 0; m_phase = 0;
      m_lfsr = 16'hACE1;
   endtask

   task automatic model_step();
      int  r;
      bit  fire;
      bit  apply;
      int  n_cnt;
      bit  n_tog;
      longint sum;
      longint d;
      if (reset) begin
         model_reset();
      end else begin
         r     = (m_rate == 0) ? 1 : m_rate;
         fire  = enable && strobe_if;
         apply = m_pflag && ((fire && (m_cnt == r - 1)) || !enable);
         if (!enable) begin
            n_cnt = 0;
            n_tog = 0;
         end else begin
            n_cnt = fire ? (m_cnt + 1) % r : m_cnt;
            n_tog = m_cic ? !m_tog : m_tog;
         end
         m_upd = apply;
         if (apply) begin
            m_rate  = m_pend;
            m_pflag = 0;
            n_cnt   = 0;
            n_tog   = 0;
         end
         m_cic = fire && (m_cfg[4] || (m_cnt == 0));
         m_cnt = n_cnt;
         m_tog = n_tog;
         if (fire) begin
            sum = (m_acc + m_freq) % PH_MOD;
            d = 0;
`ifdef WCA_DDUC_PHASE_DITHER_EN
            d = longint'(m_lfsr) % (longint'(1) << DITHER_BITS);
            m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
`endif
            m_phase = m_cfg[2] ? 0 : (sum + m_off + d) % PH_MOD;
            m_acc = sum;
         end
         if (reg_we) begin
            case (reg_addr)
               2'd0: m_freq = longint'(reg_data) % PH_MOD;
               2'd1: begin
                  m_pend  = int'(longint'(reg_data) % (longint'(1) << RATE_W));
                  m_pflag = 1;
               end
               2'd2: begin
                  m_cfg = reg_data[7:0] & 8'hBF;
                  if (reg_data[6]) m_acc = 0;
               end
               default: m_off = longint'(reg_data) % PH_MOD;
            endcase
         end
      end
      exp_q.push_back(model_vec());
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clock);
         model_step();
      end
   end

   // ------------------------------------------------------------------
   // Monitor: compare every presented output vector against the queue
   // ------------------------------------------------------------------
   initial begin
      logic [OUT_W-1:0] e;
      logic [OUT_W-1:0] a;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {cfg, rate, rate_update, log2_rate, strobe_cic, strobe_bb, phase};
            n_cmp++;
            if (a !== e) begin
               n_err++;
               $display("FAIL out_vec t=%0t got=%h expected=%h", $time, a, e);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Driver tasks
   // ------------------------------------------------------------------
   int cyc        = 0;
   int sif_period = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Advance one cycle; inputs change 1 time unit after the edge
   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
      reg_we    = 1'b0;
      strobe_if = (sif_period != 0) && (cyc % sif_period == 0);
   endtask

   task automatic write_reg(input logic [1:0] addr, input logic [31:0] data);
      reg_we   = 1'b1;
      reg_addr = addr;
      reg_data = data;
      step();
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic count_pulses(input int n, output int n_cic, output int n_bb, output int n_upd);
      n_cic = 0; n_bb = 0; n_upd = 0;
      repeat (n) begin
         step();
         n_cic += int'(strobe_cic);
         n_bb  += int'(strobe_bb);
         n_upd += int'(rate_update);
      end
   endtask

   task automatic strobe_once();
      strobe_if = 1'b1;
      step();
   endtask

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      int c_cic;
      int c_bb;
      int c_upd;
      logic [63:0] hold_phase;

      reset = 1'b1; enable = 1'b0; strobe_if = 1'b0;
      reg_we = 1'b0; reg_addr = 2'd0; reg_data = 32'd0;
      run(3);
      check("reset_rate", rate, 64'(RATE_DEFAULT));
      check("reset_cfg", cfg, 64'h0);
      check("reset_phase", phase, 64'h0);
      check("reset_strobe", {strobe_cic, strobe_bb, rate_update}, 64'h0);
      reset = 1'b0;

      // Rate 4 with halfband bypass, strobe every cycle
      enable = 1'b1;
      write_reg(2'd2, 32'h20);
      write_reg(2'd1, 32'd4);
      sif_period = 1;
      count_pulses(8, c_cic, c_bb, c_upd);
      check("r4_update_once", 64'(c_upd), 64'd1);
      check("r4_rate", rate, 64'd4);
      check("r4_log2", log2_rate, 64'd2);
      count_pulses(48, c_cic, c_bb, c_upd);
      check("r4_cic_count", 64'(c_cic), 64'd12);
      check("r4_bb_count", 64'(c_bb), 64'd12);

      // Rate 3, halfband active, strobe every 2 cycles
      write_reg(2'd2, 32'h00);
      write_reg(2'd1, 32'd3);
      sif_period = 2;
      run(24);
      check("r3_rate", rate, 64'd3);
      check("r3_log2", log2_rate, 64'd1);
      count_pulses(48, c_cic, c_bb, c_upd);
      check("r3_cic_count", 64'(c_cic), 64'd8);
      check("r3_bb_count", 64'(c_bb), 64'd4);

      // Mid-period rate change 4 -> 8
      write_reg(2'd2, 32'h20);
      write_reg(2'd1, 32'd4);
      sif_period = 1;
      run(17);
      check("r4b_rate", rate, 64'd4);
      write_reg(2'd1, 32'd8);
      check("r8_not_yet", rate, 64'd4);
      count_pulses(12, c_cic, c_bb, c_upd);
      check("r8_update_once", 64'(c_upd), 64'd1);
      check("r8_rate", rate, 64'd8);
      check("r8_log2", log2_rate, 64'd3);
      count_pulses(48, c_cic, c_bb, c_upd);
      check("r8_cic_count", 64'(c_cic), 64'd6);

      // NCO phase sequence, phase_clear, CORDIC bypass
      sif_period = 0;
      strobe_if  = 1'b0;
      write_reg(2'd2, 32'h00);
      write_reg(2'd0, 32'h1000_0000);
      write_reg(2'd3, 32'h4000_0000);
      write_reg(2'd2, 32'h40);
      check("clear_cfg", cfg, 64'h0);
      strobe_once(); check("phase_1", phase, 64'h5000_0000);
      strobe_once(); check("phase_2", phase, 64'h6000_0000);
      strobe_once(); check("phase_3", phase, 64'h7000_0000);
      strobe_once(); check("phase_4", phase, 64'h8000_0000);
      write_reg(2'd2, 32'h40);
      check("clear_cfg_2", cfg, 64'h0);
      strobe_once(); check("phase_after_clear", phase, 64'h5000_0000);
      write_reg(2'd2, 32'h04);
      strobe_once(); check("phase_bypass", phase, 64'h0);

      // Accumulator wrap
      write_reg(2'd2, 32'h00);
      write_reg(2'd3, 32'h0);
      write_reg(2'd0, 32'hF000_0000);
      write_reg(2'd2, 32'h40);
      strobe_once(); check("wrap_1", phase, 64'hF000_0000);
      strobe_once(); check("wrap_2", phase, 64'hE000_0000);

      // Drop enable mid-period, then re-enable
      write_reg(2'd1, 32'd4);
      sif_period = 1;
      run(14);
      enable = 1'b0;
      hold_phase = 64'(PHASE_W'(m_phase));
      count_pulses(4, c_cic, c_bb, c_upd);
      check("dis_no_cic", 64'(c_cic), 64'd0);
      check("dis_phase_hold", phase, hold_phase);
      enable = 1'b1;
      step();
      check("reen_first_cic", strobe_cic, 64'd1);

      // Randomised traffic
      sif_period = 0;
      for (int i = 0; i < 1500; i++) begin
         reset     = ($urandom_range(0, 199) == 0);
         enable    = ($urandom_range(0, 9) != 0);
         strobe_if = $urandom_range(0, 1);
         if ($urandom_range(0, 5) == 0) begin
            reg_we   = 1'b1;
            reg_addr = 2'($urandom_range(0, 3));
            case (reg_addr)
               2'd1:    reg_data = $urandom_range(0, 9);
               2'd2:    reg_data = $urandom_range(0, 255);
               default: reg_data = $urandom;
            endcase
         end
         @(posedge clock);
         #1;
         reg_we = 1'b0;
      end
      reset = 1'b0;

      // Mid-operation reset
      enable = 1'b1;
      write_reg(2'd1, 32'd6);
      write_reg(2'd2, 32'h37);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("mid_reset_rate", rate, 64'(RATE_DEFAULT));
      check("mid_reset_cfg", cfg, 64'h0);
      check("mid_reset_phase", phase, 64'h0);
      run(10);

      @(negedge clock);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
